// File: rtl/rv_pkg.sv
// Shared widths and bundles for the register-file write path.
// Used by the write arbiter and its result FIFO.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wr_req_t;

  typedef enum logic {
    NORMAL,
    DRAIN
  } arb_state_e;
endpackage

// File: rtl/wr_fifo.sv
// Multi-cycle result FIFO with per-entry valid bits,
// squash-by-rd and source-register match outputs.
module wr_fifo
  import rv_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  wr_req_t         push_req,
  input  logic            pop,
  input  logic            sq_en,
  input  logic [RA_W-1:0] sq_rd,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  output wr_req_t         head,
  output logic            head_vld,
  output logic [CW-1:0]   count,
  output logic            rs1_hit,
  output logic            rs2_hit
);

  wr_req_t          mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Squash first, then pop/push; a same-cycle push stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '{default: '0};
      vld   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sq_en && vld[i] && mem[i].rd == sq_rd)
          vld[i] <= 1'b0;
      end
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + 1'b1;
      end
      if (push) begin
        mem[wptr] <= push_req;
        vld[wptr] <= 1'b1;
        wptr      <= wptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head     = mem[rptr];
  assign head_vld = vld[rptr];

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && mem[i].rd == rs1) rs1_hit = 1'b1;
      if (vld[i] && mem[i].rd == rs2) rs2_hit = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between writeback
// and the multi-cycle unit, with scoreboard and starvation stall.
module regfile_wr_arbiter
  import rv_pkg::*;
#(
  parameter int  Q_DEPTH    = 2,
  parameter int  STARVE_MAX = 4,
  localparam int CW         = $clog2(Q_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mc_valid,
  output logic            mc_ready,
  input  logic [RA_W-1:0] mc_rd,
  input  logic [XLEN-1:0] mc_data,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            wb_stall,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  output logic            rs1_pend,
  output logic            rs2_pend,
  output logic [CW-1:0]   q_count
);

  localparam int SW = $clog2(STARVE_MAX) + 1;

  arb_state_e    state, state_n;
  logic [SW-1:0] starve, starve_n;
  wr_req_t       mc_req, head;
  logic          head_vld, rs1_hit, rs2_hit;
  logic          wb_wr, empty, pop, push, blocked;

  assign wb_wr    = wb_valid && (wb_rd != '0);
  assign empty    = (q_count == '0);
  assign pop      = !wb_wr && !empty;
  assign blocked  = wb_wr && !empty;
  assign mc_ready = (q_count != CW'(Q_DEPTH));
  assign push     = mc_valid && mc_ready && (mc_rd != '0);
  assign mc_req   = '{rd: mc_rd, data: mc_data};

  wr_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_req (mc_req),
    .pop      (pop),
    .sq_en    (wb_wr),
    .sq_rd    (wb_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .head     (head),
    .head_vld (head_vld),
    .count    (q_count),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit)
  );

  // A squashed head still pops, but never reaches the port.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (1'b1)
      wb_wr: begin
        rf_we    = rst_n;
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
      end
      pop && head_vld: begin
        rf_we    = rst_n;
        rf_waddr = head.rd;
        rf_wdata = head.data;
      end
      default: ;
    endcase
  end

  assign rs1_pend = rs1_hit && (rs1 != '0);
  assign rs2_pend = rs2_hit && (rs2 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= NORMAL;
      starve <= '0;
    end else begin
      state  <= state_n;
      starve <= starve_n;
    end
  end

  always_comb begin
    state_n  = state;
    starve_n = starve;
    unique case (state)
      NORMAL: begin
        if (!blocked) begin
          starve_n = '0;
        end else if (starve == SW'(STARVE_MAX - 1)) begin
          state_n  = DRAIN;
          starve_n = '0;
        end else begin
          starve_n = starve + 1'b1;
        end
      end
      DRAIN: begin
        if (empty || (pop && q_count == CW'(1))) begin
          state_n  = NORMAL;
          starve_n = '0;
        end
      end
      default: state_n = NORMAL;
    endcase
  end

  assign wb_stall = (state == DRAIN);

`ifndef SYNTHESIS
  a_no_wb_in_stall: assert property (
    @(posedge clk) disable iff (!rst_n) !(wb_stall && wb_valid));
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios, then
// randomized traffic against a queue-based reference model.
module tb_regfile_wr_arbiter;
  import rv_pkg::*;

  localparam int QD = 2;
  localparam int SM = 4;
  localparam int CW = $clog2(QD) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wb_valid, mc_valid, mc_ready;
  logic [RA_W-1:0] wb_rd, mc_rd, rf_waddr, rs1, rs2;
  logic [XLEN-1:0] wb_data, mc_data, rf_wdata;
  logic            rf_we, wb_stall, rs1_pend, rs2_pend;
  logic [CW-1:0]   q_count;

  regfile_wr_arbiter #(.Q_DEPTH(QD), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready),
    .mc_rd(mc_rd), .mc_data(mc_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_stall(wb_stall), .rs1(rs1), .rs2(rs2),
    .rs1_pend(rs1_pend), .rs2_pend(rs2_pend), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
    bit              v;
  } ent_t;

  ent_t mq[$];
  bit   m_drain;
  int   m_streak;

  task automatic idle();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    mc_valid = 0; mc_rd = 0; mc_data = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    wb_valid = 1; wb_rd = 3; wb_data = 32'h3; rs1 = 5;
    @(negedge clk);
    nvec++; if (q_count !== 0) begin nerr++; $display("FAIL rst_qcount: got %0d want 0", q_count); end
    nvec++; if (mc_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", mc_ready); end
    nvec++; if (wb_stall !== 1'b0) begin nerr++; $display("FAIL rst_stall: got %b want 0", wb_stall); end
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL rst_we: got %b want 0", rf_we); end
    nvec++; if (rs1_pend !== 1'b0) begin nerr++; $display("FAIL rst_pend: got %b want 0", rs1_pend); end
    idle();
    rst_n = 1;
    next();
    wb_valid = 1; wb_rd = 1; wb_data = 32'h1;
    mc_valid = 1; mc_rd = 5; mc_data = 32'h11;
    next();
    wb_rd = 2; mc_rd = 6; mc_data = 32'h22;
    @(negedge clk);
    nvec++; if ({rf_we, rf_waddr} !== {1'b1, 5'd2}) begin nerr++; $display("FAIL midrst_wb: got %b/%0d want 1/2", rf_we, rf_waddr); end
    nvec++; if (q_count !== 1) begin nerr++; $display("FAIL midrst_q1: got %0d want 1", q_count); end
    next();
    wb_rd = 3; mc_valid = 0; rs1 = 6;
    @(negedge clk);
    nvec++; if (q_count !== 2) begin nerr++; $display("FAIL midrst_q2: got %0d want 2", q_count); end
    nvec++; if (rs1_pend !== 1'b1) begin nerr++; $display("FAIL midrst_pend: got %b want 1", rs1_pend); end
    next();
    wb_valid = 0;
    rst_n = 0;
    #1;
    nvec++; if (q_count !== 0) begin nerr++; $display("FAIL midrst_qclr: got %0d want 0", q_count); end
    nvec++; if (mc_ready !== 1'b1) begin nerr++; $display("FAIL midrst_ready: got %b want 1", mc_ready); end
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL midrst_we: got %b want 0", rf_we); end
    nvec++; if (rs1_pend !== 1'b0) begin nerr++; $display("FAIL midrst_pclr: got %b want 0", rs1_pend); end
    @(negedge clk);
    rst_n = 1;
    next();
    @(negedge clk);
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL midrst_nowr: got %b want 0", rf_we); end
    nvec++; if (q_count !== 0) begin nerr++; $display("FAIL midrst_empty: got %0d want 0", q_count); end
    next();
  endtask

  task automatic test_mc_only();
    idle();
    mc_valid = 1; mc_rd = 8; mc_data = 32'h42; rs1 = 8;
    @(negedge clk);
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL mc_n_we: got %b want 0", rf_we); end
    nvec++; if (rs1_pend !== 1'b0) begin nerr++; $display("FAIL mc_n_pend: got %b want 0", rs1_pend); end
    next();
    mc_valid = 0;
    @(negedge clk);
    nvec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'h42}) begin nerr++; $display("FAIL mc_n1_wr: got %b/%0d/%h want 1/8/42", rf_we, rf_waddr, rf_wdata); end
    nvec++; if (rs1_pend !== 1'b1) begin nerr++; $display("FAIL mc_n1_pend: got %b want 1", rs1_pend); end
    next();
    @(negedge clk);
    nvec++; if (rs1_pend !== 1'b0) begin nerr++; $display("FAIL mc_n2_pend: got %b want 0", rs1_pend); end
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL mc_n2_we: got %b want 0", rf_we); end
    next();
  endtask

  task automatic test_priority_full();
    idle();
    wb_valid = 1; wb_rd = 10; wb_data = 32'h100;
    mc_valid = 1; mc_rd = 3; mc_data = 32'h33;
    @(negedge clk);
    nvec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'h100}) begin nerr++; $display("FAIL pri_wb0: got %b/%0d/%h want 1/10/100", rf_we, rf_waddr, rf_wdata); end
    next();
    wb_rd = 11; wb_data = 32'h101; mc_rd = 4; mc_data = 32'h44;
    @(negedge clk);
    nvec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd11, 32'h101}) begin nerr++; $display("FAIL pri_wb1: got %b/%0d/%h want 1/11/101", rf_we, rf_waddr, rf_wdata); end
    next();
    wb_rd = 12; wb_data = 32'h102; mc_rd = 5; mc_data = 32'h55;
    @(negedge clk);
    nvec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 32'h102}) begin nerr++; $display("FAIL pri_wb2: got %b/%0d/%h want 1/12/102", rf_we, rf_waddr, rf_wdata); end
    nvec++; if (q_count !== 2) begin nerr++; $display("FAIL pri_full: got %0d want 2", q_count); end
    nvec++; if (mc_ready !== 1'b0) begin nerr++; $display("FAIL pri_ready0: got %b want 0", mc_ready); end
    next();
    wb_valid = 0;
    @(negedge clk);
    nvec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h33}) begin nerr++; $display("FAIL pri_h3: got %b/%0d/%h want 1/3/33", rf_we, rf_waddr, rf_wdata); end
    nvec++; if (mc_ready !== 1'b0) begin nerr++; $display("FAIL pri_ready_pop: got %b want 0", mc_ready); end
    next();
    @(negedge clk);
    nvec++; if (mc_ready !== 1'b1) begin nerr++; $display("FAIL pri_ready1: got %b want 1", mc_ready); end
    nvec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h44}) begin nerr++; $display("FAIL pri_h4: got %b/%0d/%h want 1/4/44", rf_we, rf_waddr, rf_wdata); end
    next();
    mc_valid = 0;
    @(negedge clk);
    nvec++; if (q_count !== 1) begin nerr++; $display("FAIL pri_pushpop: got %0d want 1", q_count); end
    nvec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h55}) begin nerr++; $display("FAIL pri_h5: got %b/%0d/%h want 1/5/55", rf_we, rf_waddr, rf_wdata); end
    next();
    @(negedge clk);
    nvec++; if (q_count !== 0) begin nerr++; $display("FAIL pri_drained: got %0d want 0", q_count); end
    next();
  endtask

  task automatic test_starvation();
    idle();
    mc_valid = 1; mc_rd = 9; mc_data = 32'h99;
    wb_valid = 1; wb_rd = 1; wb_data = 32'h1000;
    next();
    mc_valid = 0;
    for (int i = 0; i < SM; i++) begin
      wb_rd = RA_W'(10 + i); wb_data = 32'h1000 + i;
      @(negedge clk);
      nvec++; if (wb_stall !== 1'b0) begin nerr++; $display("FAIL st_early%0d: got %b want 0", i, wb_stall); end
      nvec++; if ({rf_we, rf_waddr} !== {1'b1, RA_W'(10 + i)}) begin nerr++; $display("FAIL st_wb%0d: got %b/%0d want 1/%0d", i, rf_we, rf_waddr, 10 + i); end
      next();
    end
    wb_valid = !wb_stall;
    @(negedge clk);
    nvec++; if (wb_stall !== 1'b1) begin nerr++; $display("FAIL st_rise: got %b want 1", wb_stall); end
    nvec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin nerr++; $display("FAIL st_head: got %b/%0d/%h want 1/9/99", rf_we, rf_waddr, rf_wdata); end
    next();
    wb_valid = !wb_stall; wb_rd = 20;
    @(negedge clk);
    nvec++; if (wb_stall !== 1'b0) begin nerr++; $display("FAIL st_fall: got %b want 0", wb_stall); end
    nvec++; if (q_count !== 0) begin nerr++; $display("FAIL st_empty: got %0d want 0", q_count); end
    nvec++; if ({rf_we, rf_waddr} !== {1'b1, 5'd20}) begin nerr++; $display("FAIL st_resume: got %b/%0d want 1/20", rf_we, rf_waddr); end
    next();
  endtask

  task automatic test_squash();
    idle();
    mc_valid = 1; mc_rd = 7; mc_data = 32'hAA;
    next();
    mc_valid = 0; wb_valid = 1; wb_rd = 7; wb_data = 32'h55; rs1 = 7;
    @(negedge clk);
    nvec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h55}) begin nerr++; $display("FAIL sq_wb: got %b/%0d/%h want 1/7/55", rf_we, rf_waddr, rf_wdata); end
    nvec++; if (rs1_pend !== 1'b1) begin nerr++; $display("FAIL sq_pend0: got %b want 1", rs1_pend); end
    next();
    wb_valid = 0;
    @(negedge clk);
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL sq_nowr: got %b/%h want 0", rf_we, rf_wdata); end
    nvec++; if (rs1_pend !== 1'b0) begin nerr++; $display("FAIL sq_pend1: got %b want 0", rs1_pend); end
    nvec++; if (q_count !== 1) begin nerr++; $display("FAIL sq_q1: got %0d want 1", q_count); end
    next();
    @(negedge clk);
    nvec++; if (q_count !== 0) begin nerr++; $display("FAIL sq_q0: got %0d want 0", q_count); end
    next();
    wb_valid = 1; wb_rd = 7; wb_data = 32'h66;
    mc_valid = 1; mc_rd = 7; mc_data = 32'h77;
    next();
    idle(); rs1 = 7;
    @(negedge clk);
    nvec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h77}) begin nerr++; $display("FAIL sq_samecyc: got %b/%0d/%h want 1/7/77", rf_we, rf_waddr, rf_wdata); end
    nvec++; if (rs1_pend !== 1'b1) begin nerr++; $display("FAIL sq_samepend: got %b want 1", rs1_pend); end
    next();
  endtask

  task automatic test_x0();
    idle();
    mc_valid = 1; mc_rd = 0; mc_data = 32'hDEAD;
    wb_valid = 1; wb_rd = 0; wb_data = 32'hBEEF;
    @(negedge clk);
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL x0_we: got %b want 0", rf_we); end
    nvec++; if (mc_ready !== 1'b1) begin nerr++; $display("FAIL x0_ready: got %b want 1", mc_ready); end
    nvec++; if (rs1_pend !== 1'b0) begin nerr++; $display("FAIL x0_pend: got %b want 0", rs1_pend); end
    next();
    idle();
    @(negedge clk);
    nvec++; if (q_count !== 0) begin nerr++; $display("FAIL x0_q: got %0d want 0", q_count); end
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL x0_we2: got %b want 0", rf_we); end
    next();
    mc_valid = 1; mc_rd = 2; mc_data = 32'h22;
    next();
    mc_valid = 0; wb_valid = 1; wb_rd = 0;
    @(negedge clk);
    nvec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 32'h22}) begin nerr++; $display("FAIL x0_noblk: got %b/%0d/%h want 1/2/22", rf_we, rf_waddr, rf_wdata); end
    next();
    idle();
  endtask

  task automatic test_random();
    bit              wbw, pop, e_ready, e_we, e_p1, e_p2;
    logic [RA_W-1:0] e_addr;
    logic [XLEN-1:0] e_data;
    int              n0, pct;
    idle();
    rst_n = 0;
    next();
    rst_n = 1;
    mq.delete();
    m_drain = 0;
    m_streak = 0;
    for (int c = 0; c < 1500; c++) begin
      pct = (c / 100) % 3 == 0 ? 30 : ((c / 100) % 3 == 1 ? 70 : 95);
      wb_valid = !m_drain && ($urandom_range(99) < pct);
      wb_rd    = RA_W'($urandom_range(7));
      wb_data  = $urandom;
      mc_valid = 1'($urandom_range(1));
      mc_rd    = RA_W'($urandom_range(7));
      mc_data  = $urandom;
      rs1      = RA_W'($urandom_range(7));
      rs2      = RA_W'($urandom_range(7));
      @(negedge clk);
      n0 = mq.size();
      e_ready = (n0 != QD);
      wbw = wb_valid && wb_rd != 0;
      e_we = 0; e_addr = 0; e_data = 0;
      if (wbw) begin
        e_we = 1; e_addr = wb_rd; e_data = wb_data;
      end else if (n0 > 0 && mq[0].v) begin
        e_we = 1; e_addr = mq[0].rd; e_data = mq[0].data;
      end
      e_p1 = 0; e_p2 = 0;
      foreach (mq[i]) begin
        if (mq[i].v && rs1 != 0 && mq[i].rd == rs1) e_p1 = 1;
        if (mq[i].v && rs2 != 0 && mq[i].rd == rs2) e_p2 = 1;
      end
      nvec++; if (rf_we !== e_we) begin nerr++; $display("FAIL rnd_we c%0d: got %b want %b", c, rf_we, e_we); end
      if (e_we) begin
        nvec++; if (rf_waddr !== e_addr) begin nerr++; $display("FAIL rnd_addr c%0d: got %0d want %0d", c, rf_waddr, e_addr); end
        nvec++; if (rf_wdata !== e_data) begin nerr++; $display("FAIL rnd_data c%0d: got %h want %h", c, rf_wdata, e_data); end
      end
      nvec++; if (mc_ready !== e_ready) begin nerr++; $display("FAIL rnd_ready c%0d: got %b want %b", c, mc_ready, e_ready); end
      nvec++; if (q_count !== CW'(n0)) begin nerr++; $display("FAIL rnd_q c%0d: got %0d want %0d", c, q_count, n0); end
      nvec++; if (wb_stall !== m_drain) begin nerr++; $display("FAIL rnd_stall c%0d: got %b want %b", c, wb_stall, m_drain); end
      nvec++; if (rs1_pend !== e_p1) begin nerr++; $display("FAIL rnd_p1 c%0d: got %b want %b", c, rs1_pend, e_p1); end
      nvec++; if (rs2_pend !== e_p2) begin nerr++; $display("FAIL rnd_p2 c%0d: got %b want %b", c, rs2_pend, e_p2); end
      pop = !wbw && n0 > 0;
      if (wbw)
        foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].v = 0;
      if (pop) void'(mq.pop_front());
      if (mc_valid && e_ready && mc_rd != 0)
        mq.push_back('{rd: mc_rd, data: mc_data, v: 1'b1});
      if (m_drain) begin
        if (pop && n0 == 1) m_drain = 0;
      end else if (n0 > 0 && wbw) begin
        m_streak++;
        if (m_streak == SM) begin
          m_drain = 1;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
      next();
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_mc_only();
    test_priority_full();
    test_starvation();
    test_squash();
    test_x0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
